// File: rtl/definitions_pkg.sv
// definitions_pkg: shared UART constants, enums and parity-mode decode
package definitions_pkg;
   localparam int CLOCK_RATE = 50_000_000;
   localparam int BAUD_RATE  = 115_200;
   typedef enum logic [1:0] {PAR_NONE = 2'b00, PAR_EVEN = 2'b01, PAR_ODD = 2'b10} parity_mode_e;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} uart_tx_state_e;
   // Code 11 is a second encoding of "no parity".
   function automatic parity_mode_e par_mode_decode(input logic [1:0] m);
      return (m == 2'b11) ? PAR_NONE : parity_mode_e'(m);
   endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period counter producing a tick on the last clk of each bit
// Ports: clk, rst_n (async active-low), clear (hold counter at 0), enable (count),
//        tick (high during the final cycle of the current bit period)
module uart_baud_tick #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic tick
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   logic [CW-1:0] cnt;
   assign tick = enable && cnt == LAST;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (clear || !enable) cnt <= '0;
      else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter (DATA_W bits, optional parity, 1/2 stop bits)
// Ports: clk, rst_n (async active-low), enable (low aborts frame), s_valid/s_ready/s_data
//        input handshake with per-word s_par_mode (00 none, 01 even, 10 odd, 11 none) and
//        s_stop2, busy (state != IDLE), done (last stop-bit cycle pulse), tx (idle high).
// Build option: UART_TX_BREAK_EN adds input brk to send a line break followed by one mark bit.
module uart_tx_frame
   import definitions_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   input  logic [1:0]        s_par_mode,
   input  logic              s_stop2,
`ifdef UART_TX_BREAK_EN
   input  logic              brk,
`endif
   output logic              s_ready,
   output logic              busy,
   output logic              done,
   output logic              tx
);
   localparam int IW = $clog2(DATA_W);
   localparam logic [IW-1:0] LAST_BIT = IW'(DATA_W - 1);
   uart_tx_state_e    state;
   parity_mode_e      mode;
   logic [DATA_W-1:0] shreg;
   logic [IW-1:0]     bit_idx;
   logic              par_en, par_bit, stop2_q, stop_idx;
   logic              tick, clear, last_stop, accept, brk_req;
`ifdef UART_TX_BREAK_EN
   assign brk_req = brk;
`else
   assign brk_req = 1'b0;
`endif
   assign mode      = par_mode_decode(s_par_mode);
   assign last_stop = state == STOP && tick && (!stop2_q || stop_idx);
   assign s_ready   = rst_n && enable && !brk_req && (state == IDLE || last_stop);
   assign accept    = s_valid && s_ready;
   assign done      = last_stop;
   assign busy      = state != IDLE;
   // The break itself has no fixed length, so the counter only runs during the trailing mark bit.
   assign clear     = state == IDLE || (state == BREAK && !tx);
   uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (clear),
      .enable (enable),
      .tick   (tick)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state    <= IDLE;
         tx       <= 1'b1;
         shreg    <= '0;
         bit_idx  <= '0;
         par_en   <= 1'b0;
         par_bit  <= 1'b0;
         stop2_q  <= 1'b0;
         stop_idx <= 1'b0;
      end else if (!enable) begin
         state <= IDLE;
         tx    <= 1'b1;
      end else if (accept) begin
         state   <= START;
         tx      <= 1'b0;
         shreg   <= s_data;
         par_en  <= mode != PAR_NONE;
         par_bit <= ^s_data ^ (mode == PAR_ODD);
         stop2_q <= s_stop2;
      end else if (brk_req && (state == IDLE || last_stop)) begin
         state <= BREAK;
         tx    <= 1'b0;
      end else
         case (state)
            START:
               if (tick) begin
                  state   <= DATA;
                  tx      <= shreg[0];
                  bit_idx <= '0;
               end
            DATA:
               if (tick) begin
                  if (bit_idx == LAST_BIT) begin
                     state    <= par_en ? PARITY : STOP;
                     tx       <= par_en ? par_bit : 1'b1;
                     stop_idx <= 1'b0;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                     shreg   <= shreg >> 1;
                     tx      <= shreg[1];
                  end
               end
            PARITY:
               if (tick) begin
                  state <= STOP;
                  tx    <= 1'b1;
               end
            STOP:
               if (tick) begin
                  if (last_stop) state <= IDLE;
                  else stop_idx <= 1'b1;
               end
            BREAK:
               if (!tx) tx <= !brk_req;
               else if (tick) state <= IDLE;
            default: ;
         endcase
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: scoreboard bench for uart_tx_frame (CLKS_PER_BIT=4, DATA_W=8 and 5)
module tb_uart_tx_frame;
   localparam int CPB = 4;
   typedef struct {
      logic [15:0] bits;
      int          n;
   } frame_t;
   logic       clk, rst_n, enable, s_valid, s_stop2, s_ready, busy, done, tx;
   logic [7:0] s_data;
   logic [1:0] s_par_mode;
   logic       v5, r5, b5, dn5, tx5;
   logic [4:0] d5;
`ifdef UART_TX_BREAK_EN
   logic       brk;
`endif
   int         checks, failures, mon_cyc;
   logic       mon_act, mon_on, acc_done;
   frame_t     cur, f5;
   frame_t     exp_q[$];

   uart_tx_frame #(.DATA_W(8), .CLKS_PER_BIT(CPB)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .s_valid    (s_valid),
      .s_data     (s_data),
      .s_par_mode (s_par_mode),
      .s_stop2    (s_stop2),
`ifdef UART_TX_BREAK_EN
      .brk        (brk),
`endif
      .s_ready    (s_ready),
      .busy       (busy),
      .done       (done),
      .tx         (tx)
   );
   uart_tx_frame #(.DATA_W(5), .CLKS_PER_BIT(CPB)) u_dut5 (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .s_valid    (v5),
      .s_data     (d5),
      .s_par_mode (2'b10),
      .s_stop2    (1'b0),
`ifdef UART_TX_BREAK_EN
      .brk        (1'b0),
`endif
      .s_ready    (r5),
      .busy       (b5),
      .done       (dn5),
      .tx         (tx5)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic frame_t mk(input logic [8:0] d, input int w, input logic [1:0] m, input logic s2);
      frame_t f;
      int     k;
      logic   p;
      f.bits    = '1;
      f.bits[0] = 1'b0;
      k = 1;
      p = 1'b0;
      for (int i = 0; i < w; i++) begin
         f.bits[k] = d[i];
         p ^= d[i];
         k++;
      end
      if (m == 2'b01 || m == 2'b10) begin
         f.bits[k] = (m == 2'b10) ? ~p : p;
         k++;
      end
      f.n = k + (s2 ? 2 : 1);
      return f;
   endfunction

   always @(negedge clk) begin
      if (!mon_on || !rst_n) mon_act = 1'b0;
      else begin
         if (!mon_act && busy && !tx) begin
            if (exp_q.size() == 0) check("sb_unexpected_frame", 1, 0);
            else begin
               cur     = exp_q.pop_front();
               mon_act = 1'b1;
               mon_cyc = 0;
            end
         end
         if (mon_act) begin
            check("tx_bit", tx, cur.bits[mon_cyc / CPB]);
            check("done", done, mon_cyc == cur.n * CPB - 1);
            check("busy", busy, 1);
            mon_cyc++;
            if (mon_cyc == cur.n * CPB) mon_act = 1'b0;
         end
      end
   end

   task automatic send(input logic [7:0] d, input logic [1:0] m, input logic s2);
      int n;
      n = 0;
      @(negedge clk);
      s_valid    = 1'b1;
      s_data     = d;
      s_par_mode = m;
      s_stop2    = s2;
      while (!s_ready && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready) begin
         check("send_timeout", 0, 1);
         s_valid = 1'b0;
         return;
      end
      acc_done = done;
      @(posedge clk);
      exp_q.push_back(mk({1'b0, d}, 8, m, s2));
      #1 s_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (busy) check("idle_timeout", 0, 1);
      @(negedge clk);
   endtask

   initial begin
      clk = 0; rst_n = 1; enable = 1; s_valid = 0; s_data = 0; s_par_mode = 0; s_stop2 = 0;
      v5 = 0; d5 = 0; mon_on = 1; mon_act = 0; mon_cyc = 0; acc_done = 0; checks = 0; failures = 0;
`ifdef UART_TX_BREAK_EN
      brk = 0;
`endif
      #1 rst_n = 0;
      repeat (3) @(negedge clk);
      check("rst_tx", tx, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ready", s_ready, 0);
      rst_n = 1;
      @(negedge clk);
      check("idle_ready", s_ready, 1);
      send(8'hA5, 2'b00, 1'b0); wait_idle();
      send(8'h07, 2'b01, 1'b1); wait_idle();
      send(8'h07, 2'b10, 1'b1); wait_idle();
      send(8'hC3, 2'b11, 1'b0); wait_idle();
      send(8'h55, 2'b00, 1'b0);
      send(8'hAA, 2'b00, 1'b0);
      check("b2b_accept_in_last_stop", acc_done, 1);
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         check("b2b_busy", busy, 1);
         if (done) break;
      end
      wait_idle();
      send(8'h3C, 2'b01, 1'b0);
      s_data = 8'hFF; s_par_mode = 2'b10; s_stop2 = 1'b1;
      wait_idle();
      check("sb_drained", exp_q.size(), 0);
      mon_on = 0;
      send(8'hF7, 2'b00, 1'b0);
      repeat (17) @(posedge clk);
      @(negedge clk);
      check("abort_pre_tx", tx, 0);
      check("abort_pre_busy", busy, 1);
      enable = 0;
      @(negedge clk);
      check("abort_tx", tx, 1);
      check("abort_busy", busy, 0);
      check("abort_ready", s_ready, 0);
      repeat (8) begin
         @(negedge clk);
         check("abort_no_done", done, 0);
         check("abort_ready_low", s_ready, 0);
      end
      enable = 1;
      #1 check("abort_ready_back", s_ready, 1);
      exp_q.delete();
      send(8'h12, 2'b01, 1'b1);
      repeat (10) @(posedge clk);
      #2 check("rst_mid_busy_pre", busy, 1);
      #1 rst_n = 0;
      #1 check("rst_mid_tx", tx, 1);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_ready", s_ready, 0);
      check("rst_mid_done", done, 0);
      repeat (2) @(negedge clk);
      rst_n = 1;
      exp_q.delete();
      @(negedge clk);
      f5 = mk(9'h01F, 5, 2'b10, 1'b0);
      check("w5_frame_len", f5.n * CPB, 32);
      v5 = 1; d5 = 5'h1F;
      for (int i = 0; i < 20 && !r5; i++) @(negedge clk);
      check("w5_ready", r5, 1);
      @(posedge clk);
      #1 v5 = 0;
      for (int c = 0; c < 32; c++) begin
         @(negedge clk);
         check("w5_tx", tx5, f5.bits[c / CPB]);
         check("w5_done", dn5, c == 31);
      end
      @(negedge clk);
      check("w5_idle", b5, 0);
`ifdef UART_TX_BREAK_EN
      @(negedge clk);
      brk = 1;
      repeat (20) begin
         @(negedge clk);
         check("brk_tx_low", tx, 0);
         check("brk_ready", s_ready, 0);
         check("brk_busy", busy, 1);
      end
      brk = 0;
      repeat (4) begin
         @(negedge clk);
         check("brk_mark", tx, 1);
         check("brk_mark_ready", s_ready, 0);
      end
      @(negedge clk);
      check("brk_end_ready", s_ready, 1);
      check("brk_end_busy", busy, 0);
`endif
      mon_on = 1;
      send(8'h81, 2'b10, 1'b0); wait_idle();
      check("sb_empty_end", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
